// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide,
// sign fix-up in a final cycle, one-cycle write strobe toward the register file.
//
// state  | meaning
// IDLE   | waiting for start; special divide cases resolve here straight to DONE
// CALC   | one multiplier bit (LSB first) or quotient bit (MSB first) per cycle
// FIX    | sign correction and result selection, result registered
// DONE   | done/wr_en high for one cycle; a waiting start is taken on the exit edge
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wr_addr,
  output logic            wr_en
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      wr_addr_q, wr_addr_d;

  logic            in_signed_a, in_signed_b;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  always_comb begin
    in_signed_a = 1'b0;
    in_signed_b = 1'b0;
    if (funct3[2]) begin
      in_signed_a = ~funct3[0];
      in_signed_b = ~funct3[0];
    end else begin
      in_signed_a = (funct3 == 3'b001) || (funct3 == 3'b010);
      in_signed_b = (funct3 == 3'b001);
    end
    neg_a    = in_signed_a & rs1_data[XLEN-1];
    neg_b    = in_signed_b & rs2_data[XLEN-1];
    mag_a    = neg_a ? -rs1_data : rs1_data;
    mag_b    = neg_b ? -rs2_data : rs2_data;
    div_zero = funct3[2] && (rs2_data == '0);
    div_ovf  = funct3[2] && !funct3[0] && (rs1_data == INT_MIN) && (rs2_data == '1);
  end

  // acc holds the product high half / partial remainder; lo the multiplier / quotient
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_trial = {acc_q, lo_q[XLEN-1]};
    prod_fix  = (sign_a_q ^ sign_b_q) ? -{acc_q, lo_q} : {acc_q, lo_q};
    quo_fix   = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
    rem_fix   = sign_a_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    b_d       = b_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    result_d  = result_q;
    wr_addr_d = wr_addr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start) begin
          op_d      = funct3;
          wr_addr_d = rd_addr;
          cnt_d     = '0;
          acc_d     = '0;
          lo_d      = mag_a;
          b_d       = mag_b;
          sign_a_d  = neg_a;
          sign_b_d  = neg_b;
          if (div_zero) begin
            result_d = funct3[1] ? rs1_data : '1;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = funct3[1] ? '0 : INT_MIN;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (op_q[2]) begin
          if (div_trial >= {1'b0, b_q}) begin
            acc_d = div_trial[XLEN-1:0] - b_q;
            lo_d  = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = div_trial[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          acc_d = mul_sum[XLEN:1];
          lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        case (op_q)
          3'b000:                 result_d = prod_fix[XLEN-1:0];
          3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
          3'b100, 3'b101:         result_d = quo_fix;
          default:                result_d = rem_fix;
        endcase
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      result_q  <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      b_q       <= b_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      result_q  <= result_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign wr_en   = done;
  assign result  = result_q;
  assign wr_addr = wr_addr_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, abort/ignore behaviour,
// back-to-back issue and random operations against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk, rst, start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_addr;
  logic        busy, done, wr_en;
  logic [31:0] result;
  logic [4:0]  wr_addr;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .busy(busy), .done(done), .result(result), .wr_addr(wr_addr), .wr_en(wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, q;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * longint'(ub); return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        q = sa / sb; return q[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        q = sa % sb; return q[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // inject_at > 0 drives a foreign start pulse sampled at that edge after the start edge
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input string tag, input int inject_at);
    logic [31:0] exp;
    int          exp_n, n;
    bit          busy_ok;
    exp   = model(f, a, b);
    exp_n = is_special(f, a, b) ? 0 : 33;
    @(negedge clk);
    funct3 = f; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_addr = 5'($urandom);
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (n == inject_at - 1) begin
        start = 1'b1; funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'(exp_n));
    chk({tag, "_busy"}, {31'b0, busy_ok & busy}, 32'd1);
    chk({tag, "_result"}, result, exp);
    chk({tag, "_wr_addr"}, {27'b0, wr_addr}, {27'b0, rd});
    chk({tag, "_wr_en"}, {31'b0, wr_en}, 32'd1);
    @(posedge clk); #1;
    chk({tag, "_done_single"}, {30'b0, done, wr_en}, 32'd0);
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    chk({tag, "_hold"}, result, exp);
  endtask

  initial begin : stim
    logic [2:0]  bf [3];
    logic [31:0] ba [3];
    logic [31:0] bb [3];
    logic [31:0] prev;
    logic [2:0]  f;
    logic [31:0] a, b;
    int          n, sel;
    bit          saw_done;

    rst = 1'b1; start = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_wr_addr", {27'b0, wr_addr}, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, "mul", 0);
    run_op(3'b001, 32'h80000000, 32'h80000000, 5'd1, "mulh", 0);
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, "mulhu", 0);
    run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, "mulhsu", 0);
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, 5'd4, "div", 0);
    run_op(3'b110, 32'hFFFFFFF9, 32'd2, 5'd6, "rem", 0);
    run_op(3'b101, 32'hFFFFFFFF, 32'd2, 5'd7, "divu", 0);
    run_op(3'b111, 32'd100, 32'd7, 5'd8, "remu", 0);
    run_op(3'b100, 32'd5, 32'd0, 5'd9, "div_by0", 0);
    run_op(3'b111, 32'd5, 32'd0, 5'd10, "remu_by0", 0);
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd11, "div_ovf", 0);
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd12, "rem_ovf", 0);
    run_op(3'b000, 32'd0, 32'd9, 5'd0, "mul_x0", 0);
    run_op(3'b000, 32'h00001234, 32'h00005678, 5'd13, "ignore_start", 10);

    // reset in the middle of a divide
    @(negedge clk);
    funct3 = 3'b100; rs1_data = 32'd1000; rs2_data = 32'd7; rd_addr = 5'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_wr_addr", {27'b0, wr_addr}, 32'd0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort_no_done", {31'b0, saw_done}, 32'd0);
    run_op(3'b000, 32'd3, 32'd4, 5'd14, "mul_after_abort", 0);

    // reset wins over start
    @(negedge clk);
    funct3 = 3'b000; rs1_data = 32'd2; rs2_data = 32'd2; start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_over_start", {31'b0, busy}, 32'd0);
    @(negedge clk); rst = 1'b0; start = 1'b0;

    // back-to-back with start held high
    for (int i = 0; i < 3; i++) begin
      bf[i] = 3'($urandom);
      ba[i] = $urandom;
      bb[i] = {1'b0, 31'($urandom)} | 32'd1;
    end
    prev = 32'd0;
    @(negedge clk);
    funct3 = bf[0]; rs1_data = ba[0]; rs2_data = bb[0]; rd_addr = 5'd20; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      if (k < 2) begin
        funct3 = bf[k+1]; rs1_data = ba[k+1]; rs2_data = bb[k+1]; rd_addr = 5'(21 + k);
      end else begin
        start = 1'b0;
      end
      n = 0;
      while (!done && n < 40) begin
        if (n == 16) chk("b2b_hold", result, prev);
        @(posedge clk); #1;
        n++;
      end
      chk("b2b_latency", 32'(n), 32'd33);
      chk("b2b_result", result, model(bf[k], ba[k], bb[k]));
      chk("b2b_wr_addr", {27'b0, wr_addr}, 32'(20 + k));
      prev = model(bf[k], ba[k], bb[k]);
      @(posedge clk); #1;
      chk("b2b_busy", {31'b0, busy}, (k < 2) ? 32'd1 : 32'd0);
      chk("b2b_done_single", {31'b0, done}, 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      run_op(f, a, b, 5'($urandom), "rand", 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
